// File: rtl/vram_scan_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vram_scan_arbiter_if                                          |
// | Purpose  : Bundles the signals around vram_scan_arbiter: video timing    |
// |            inputs, the single-port frame memory port, the scanout pixel  |
// |            output and the CPU request/acknowledge port.                  |
// | Modports : master - arbiter side (consumes I_*, drives O_*)              |
// |            slave  - environment side (drives I_*, consumes O_*)          |
// | Signals  : I_clk_rise    pixel-clock rise strobe                         |
// |            I_hcount     horizontal counter                               |
// |            I_vcount     vertical counter                                 |
// |            O_mem_addr   memory address                                   |
// |            O_mem_we     memory write enable                              |
// |            O_mem_wdata  memory write data                                |
// |            I_mem_rdata  memory read data (1 cycle after address)         |
// |            O_pixel      fetched scanout pixel                            |
// |            O_pixel_valid one-cycle pixel update strobe                   |
// |            I_cpu_req/we/addr/wdata  CPU request, held until ack          |
// |            O_cpu_ack    one-cycle CPU completion strobe                  |
// |            O_cpu_rdata  CPU read data, held after ack                    |
// |            O_stall_count CPU stall statistics                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface vram_scan_arbiter_if #(
  parameter int P_addr_width = 16,
  parameter int P_data_width = 8
);
  logic                    I_clk_rise;
  logic [15:0]             I_hcount;
  logic [15:0]             I_vcount;
  logic [P_addr_width-1:0] O_mem_addr;
  logic                    O_mem_we;
  logic [P_data_width-1:0] O_mem_wdata;
  logic [P_data_width-1:0] I_mem_rdata;
  logic [P_data_width-1:0] O_pixel;
  logic                    O_pixel_valid;
  logic                    I_cpu_req;
  logic                    I_cpu_we;
  logic [P_addr_width-1:0] I_cpu_addr;
  logic [P_data_width-1:0] I_cpu_wdata;
  logic                    O_cpu_ack;
  logic [P_data_width-1:0] O_cpu_rdata;
  logic [15:0]             O_stall_count;

  modport master (
    input  I_clk_rise, I_hcount, I_vcount, I_mem_rdata,
    input  I_cpu_req, I_cpu_we, I_cpu_addr, I_cpu_wdata,
    output O_mem_addr, O_mem_we, O_mem_wdata,
    output O_pixel, O_pixel_valid,
    output O_cpu_ack, O_cpu_rdata, O_stall_count
  );

  modport slave (
    output I_clk_rise, I_hcount, I_vcount, I_mem_rdata,
    output I_cpu_req, I_cpu_we, I_cpu_addr, I_cpu_wdata,
    input  O_mem_addr, O_mem_we, O_mem_wdata,
    input  O_pixel, O_pixel_valid,
    input  O_cpu_ack, O_cpu_rdata, O_stall_count
  );
endinterface
`default_nettype wire

// File: rtl/vram_scan_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vram_scan_arbiter                                             |
// | Purpose  : Shares one single-port synchronous pixel memory between the   |
// |            scanout fetch and a CPU request/ack port. Slot 0 of every     |
// |            4-cycle pixel period is reserved for the video read while     |
// |            the timing counters are inside the active window; the CPU     |
// |            takes any other free cycle, at most every second cycle.       |
// | Ports    : I_clock  system clock                                         |
// |            I_reset  synchronous active-low reset                         |
// |            bus      vram_scan_arbiter_if.master (timing, memory, pixel   |
// |                     and CPU signals; see the interface header)           |
// | Options  : VRAM_ARB_STATS_EN - build the saturating CPU stall counter;   |
// |            otherwise O_stall_count is tied to zero.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vram_scan_arbiter #(
  parameter int P_addr_width = 16,
  parameter int P_data_width = 8,
  parameter int P_active_h   = 256,
  parameter int P_active_v   = 240,
  parameter int P_base       = 0
) (
  input  logic                I_clock,
  input  logic                I_reset,
  vram_scan_arbiter_if.master bus
);

  // Tag of the access whose read data / completion is due in the next cycle.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VIDEO  = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } tag_e;

  logic [1:0]              slot_q, slot_d;
  tag_e                    tag_q, tag_d;
  logic [P_addr_width-1:0] addr_q, addr_d;
  logic [P_data_width-1:0] wdata_q, wdata_d;
  logic [P_data_width-1:0] pixel_q, pixel_d;
  logic [P_data_width-1:0] cpu_rdata_q, cpu_rdata_d;

  logic [1:0]              w_slot;
  logic                    w_window;
  logic                    w_video_issue;
  logic                    w_ret_cpu;
  logic                    w_cpu_ack;
  logic                    w_cpu_grant;
  logic                    w_pixel_valid;
  logic [P_addr_width-1:0] w_video_addr;
  logic [P_addr_width-1:0] w_mem_addr;
  logic                    w_mem_we;
  logic [P_data_width-1:0] w_mem_wdata;
  logic [P_data_width-1:0] w_pixel;
  logic [P_data_width-1:0] w_cpu_rdata;

  always_comb begin
    // The strobe cycle itself is slot 0, so the counter resynchronises
    // immediately whatever the spacing between strobes.
    w_slot = bus.I_clk_rise ? 2'd0 : slot_q;
    slot_d = w_slot + 2'd1;

    w_window = ({16'd0, bus.I_vcount} < P_active_v) &&
               ({16'd0, bus.I_hcount} < P_active_h);

    // Computed at address width so that the sum wraps modulo 2^P_addr_width.
    w_video_addr = P_addr_width'(P_base)
                 + P_addr_width'(bus.I_vcount) * P_addr_width'(P_active_h)
                 + P_addr_width'(bus.I_hcount);

    // Everything is gated by I_reset so that all outputs read 0 while reset
    // is held and an in-flight CPU read can never complete into reset.
    w_video_issue = I_reset && (w_slot == 2'd0) && w_window;
    w_ret_cpu     = (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_WR);
    w_cpu_ack     = I_reset && w_ret_cpu;
    // No grant while a CPU access is returning: the request is still high
    // during its own ack cycle and must not be serviced twice.
    w_cpu_grant   = I_reset && bus.I_cpu_req && !w_video_issue && !w_ret_cpu;
    w_pixel_valid = I_reset && (tag_q == TAG_VIDEO);

    // Issue stage: address/data hold their last value when idle.
    w_mem_addr  = addr_q;
    w_mem_wdata = wdata_q;
    w_mem_we    = 1'b0;
    if (!I_reset) begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
    end else if (w_video_issue) begin
      w_mem_addr  = w_video_addr;
    end else if (w_cpu_grant) begin
      w_mem_addr  = bus.I_cpu_addr;
      w_mem_wdata = bus.I_cpu_wdata;
      w_mem_we    = bus.I_cpu_we;
    end

    // Return stage: read data is presented in the cycle it arrives and is
    // then held by the output registers.
    w_pixel = I_reset ? pixel_q : '0;
    if (w_pixel_valid) begin
      w_pixel = bus.I_mem_rdata;
    end
    w_cpu_rdata = I_reset ? cpu_rdata_q : '0;
    if (w_cpu_ack && (tag_q == TAG_CPU_RD)) begin
      w_cpu_rdata = bus.I_mem_rdata;
    end

    tag_d = TAG_NONE;
    if (w_video_issue) begin
      tag_d = TAG_VIDEO;
    end else if (w_cpu_grant) begin
      tag_d = bus.I_cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    end

    addr_d      = w_mem_addr;
    wdata_d     = w_mem_wdata;
    pixel_d     = w_pixel;
    cpu_rdata_d = w_cpu_rdata;
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      slot_q      <= 2'd0;
      tag_q       <= TAG_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      pixel_q     <= '0;
      cpu_rdata_q <= '0;
    end else begin
      slot_q      <= slot_d;
      tag_q       <= tag_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pixel_q     <= pixel_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.O_mem_addr    = w_mem_addr;
  assign bus.O_mem_we      = w_mem_we;
  assign bus.O_mem_wdata   = w_mem_wdata;
  assign bus.O_pixel       = w_pixel;
  assign bus.O_pixel_valid = w_pixel_valid;
  assign bus.O_cpu_ack     = w_cpu_ack;
  assign bus.O_cpu_rdata   = w_cpu_rdata;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic        w_frame_start;

  always_comb begin
    w_frame_start = bus.I_clk_rise && (bus.I_hcount == 16'd0) &&
                    (bus.I_vcount == 16'd0);
    stall_d = stall_q;
    // Frame start wins over a simultaneous stall so each frame starts at 0.
    if (w_frame_start) begin
      stall_d = 16'd0;
    end else if (bus.I_cpu_req && !w_cpu_grant && !w_cpu_ack &&
                 (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.O_stall_count = I_reset ? stall_q : 16'd0;
`else
  assign bus.O_stall_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_scan_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vram_scan_arbiter                                          |
// | Purpose  : Self-checking bench for vram_scan_arbiter. A cycle table of   |
// |            inputs and hand-computed outputs, followed by hand-written    |
// |            sequences for back-to-back CPU access, reset during a read    |
// |            and a bounded wait on a CPU write during a collision.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vram_scan_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  vram_scan_arbiter_if #(.P_addr_width(16), .P_data_width(8)) bus ();

  vram_scan_arbiter #(
    .P_addr_width(16),
    .P_data_width(8),
    .P_active_h  (256),
    .P_active_v  (240),
    .P_base      (0)
  ) dut (
    .I_clock(clk),
    .I_reset(rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rst_n;
    logic        rise;
    logic [15:0] h;
    logic [15:0] v;
    logic        req;
    logic        we;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic [7:0]  rdata;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_pix;
    logic        e_pv;
    logic        e_ack;
    logic [7:0]  e_crd;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rs, input logic rise, input logic [15:0] h,
                     input logic [15:0] v, input logic req, input logic we,
                     input logic [15:0] caddr, input logic [7:0] cwd,
                     input logic [7:0] rdata, input logic [15:0] e_addr,
                     input logic e_we, input logic [7:0] e_pix,
                     input logic e_pv, input logic e_ack,
                     input logic [7:0] e_crd, input logic [15:0] e_stall);
    vec_t x;
    x.rst_n = rs;  x.rise = rise; x.h = h; x.v = v;
    x.req = req;   x.we = we;     x.caddr = caddr; x.cwd = cwd;
    x.rdata = rdata;
    x.e_addr = e_addr; x.e_we = e_we; x.e_pix = e_pix; x.e_pv = e_pv;
    x.e_ack = e_ack;   x.e_crd = e_crd; x.e_stall = e_stall;
    vt.push_back(x);
  endtask

  task automatic drive(input logic rs, input logic rise, input logic [15:0] h,
                       input logic [15:0] v, input logic req, input logic we,
                       input logic [15:0] caddr, input logic [7:0] cwd,
                       input logic [7:0] rdata);
    rst_n           = rs;
    bus.I_clk_rise  = rise;
    bus.I_hcount    = h;
    bus.I_vcount    = v;
    bus.I_cpu_req   = req;
    bus.I_cpu_we    = we;
    bus.I_cpu_addr  = caddr;
    bus.I_cpu_wdata = cwd;
    bus.I_mem_rdata = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] stall_exp(input logic [15:0] e);
`ifdef VRAM_ARB_STATS_EN
    return e;
`else
    return 16'd0 & e;
`endif
  endfunction

  initial begin
    int    ack_at;
    int    ack_cnt;
    string n;
    checks = 0;
    fails  = 0;
    drive(1'b0, 1'b0, 16'd0, 16'd300, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);

    //  rst rise  h    v    req we caddr    cwd    rdata | addr    we pix   pv ack crd   stall
    add(0, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0000, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0000, 0, 8'h00, 0, 0, 8'h00, 0);
    // scanout fetch
    add(1, 1,   5,   1, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0105, 0, 8'h00, 0, 0, 8'h00, 0);
    add(1, 0,   5,   1, 0, 0, 16'h0000, 8'h00, 8'hA5,  16'h0105, 0, 8'hA5, 1, 0, 8'h00, 0);
    add(1, 0,   5,   1, 0, 0, 16'h0000, 8'h00, 8'h11,  16'h0105, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,   6,   1, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0105, 0, 8'hA5, 0, 0, 8'h00, 0);
    // CPU write in vertical blanking
    add(1, 1,   0, 245, 1, 1, 16'h1234, 8'h3C, 8'h00,  16'h1234, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,   0, 245, 1, 1, 16'h1234, 8'h3C, 8'h00,  16'h1234, 0, 8'hA5, 0, 1, 8'h00, 0);
    add(1, 0,   1, 245, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h1234, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,   1, 245, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h1234, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 1,   2, 245, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h1234, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,   2, 245, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h1234, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,   3, 245, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h1234, 0, 8'hA5, 0, 0, 8'h00, 0);
    // collision 1: CPU read at reserved slot 0
    add(1, 1,  10,   0, 1, 0, 16'h0042, 8'h00, 8'h00,  16'h000A, 0, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 0,  10,   0, 1, 0, 16'h0042, 8'h00, 8'h77,  16'h0042, 0, 8'h77, 1, 0, 8'h00, 1);
    add(1, 0,  10,   0, 1, 0, 16'h0042, 8'h00, 8'h5A,  16'h0042, 0, 8'h77, 0, 1, 8'h5A, 1);
    add(1, 0,  11,   0, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0042, 0, 8'h77, 0, 0, 8'h5A, 1);
    // collision 2 at the last active pixel
    add(1, 1, 255, 239, 1, 0, 16'hFFFF, 8'h00, 8'h00,  16'hEFFF, 0, 8'h77, 0, 0, 8'h5A, 1);
    add(1, 0, 255, 239, 1, 0, 16'hFFFF, 8'h00, 8'h81,  16'hFFFF, 0, 8'h81, 1, 0, 8'h5A, 2);
    add(1, 0, 255, 239, 1, 0, 16'hFFFF, 8'h00, 8'h19,  16'hFFFF, 0, 8'h81, 0, 1, 8'h19, 2);
    add(1, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'hFFFF, 0, 8'h81, 0, 0, 8'h19, 2);
    // collision 3
    add(1, 1,   0, 100, 1, 0, 16'h0003, 8'h00, 8'h00,  16'h6400, 0, 8'h81, 0, 0, 8'h19, 2);
    add(1, 0,   0, 100, 1, 0, 16'h0003, 8'h00, 8'hC3,  16'h0003, 0, 8'hC3, 1, 0, 8'h19, 3);
    add(1, 0,   0, 100, 1, 0, 16'h0003, 8'h00, 8'hE7,  16'h0003, 0, 8'hC3, 0, 1, 8'hE7, 3);
    add(1, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    // window edges: h=256 and v=240 are outside
    add(1, 1, 256,   0, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    add(1, 0, 256,   0, 0, 0, 16'h0000, 8'h00, 8'h55,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    add(1, 1,   0, 240, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    add(1, 0,   0, 240, 0, 0, 16'h0000, 8'h00, 8'h66,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    // CPU grant in slot 3, its return coincides with a video issue
    add(1, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0003, 0, 8'hC3, 0, 0, 8'hE7, 3);
    add(1, 0,   0, 300, 1, 0, 16'h0055, 8'h00, 8'h00,  16'h0055, 0, 8'hC3, 0, 0, 8'hE7, 3);
    add(1, 1,   1,   0, 1, 0, 16'h0055, 8'h00, 8'h6C,  16'h0001, 0, 8'hC3, 0, 1, 8'h6C, 3);
    add(1, 0,   1,   0, 0, 0, 16'h0000, 8'h00, 8'h9D,  16'h0001, 0, 8'h9D, 1, 0, 8'h6C, 3);
    add(1, 0,   1,   0, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0001, 0, 8'h9D, 0, 0, 8'h6C, 3);
    // frame-start strobe clears the stall counter
    add(1, 1,   0,   0, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0000, 0, 8'h9D, 0, 0, 8'h6C, 3);
    add(1, 0,   0,   0, 0, 0, 16'h0000, 8'h00, 8'h3E,  16'h0000, 0, 8'h3E, 1, 0, 8'h6C, 0);
    add(1, 0,   0, 300, 0, 0, 16'h0000, 8'h00, 8'h00,  16'h0000, 0, 8'h3E, 0, 0, 8'h6C, 0);

    @(posedge clk); #1;
    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].rise, vt[i].h, vt[i].v, vt[i].req, vt[i].we,
            vt[i].caddr, vt[i].cwd, vt[i].rdata);
      @(negedge clk);
      n = $sformatf("vec%0d", i);
      chk({n, " mem_addr"},    32'(bus.O_mem_addr),    32'(vt[i].e_addr));
      chk({n, " mem_we"},      32'(bus.O_mem_we),      32'(vt[i].e_we));
      chk({n, " pixel"},       32'(bus.O_pixel),       32'(vt[i].e_pix));
      chk({n, " pixel_valid"}, 32'(bus.O_pixel_valid), 32'(vt[i].e_pv));
      chk({n, " cpu_ack"},     32'(bus.O_cpu_ack),     32'(vt[i].e_ack));
      chk({n, " cpu_rdata"},   32'(bus.O_cpu_rdata),   32'(vt[i].e_crd));
      chk({n, " stall_count"}, 32'(bus.O_stall_count), 32'(stall_exp(vt[i].e_stall)));
      if (!vt[i].rst_n || vt[i].e_we) begin
        chk({n, " mem_wdata"}, 32'(bus.O_mem_wdata),
            vt[i].rst_n ? 32'(vt[i].cwd) : 32'd0);
      end
      @(posedge clk); #1;
    end

    // Back-to-back CPU reads outside the window: grant, ack, grant, ack ...
    ack_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), 16'd0, 16'd300, 1'b1, 1'b0, 16'h0100, 8'h00,
            8'(8'hB0 + i));
      @(negedge clk);
      n = $sformatf("b2b%0d", i);
      chk({n, " cpu_ack"}, 32'(bus.O_cpu_ack), 32'(i % 2));
      if (i % 2 == 0) begin
        chk({n, " grant addr"}, 32'(bus.O_mem_addr), 32'h0100);
      end else begin
        chk({n, " cpu_rdata"}, 32'(bus.O_cpu_rdata), 32'(8'hB0 + i));
      end
      if (bus.O_cpu_ack) ack_cnt++;
      @(posedge clk); #1;
    end
    chk("b2b ack count", 32'(ack_cnt), 32'd4);

    // Reset while a CPU read is in flight.
    drive(1'b1, 1'b0, 16'd0, 16'd300, 1'b1, 1'b0, 16'h0077, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst grant addr", 32'(bus.O_mem_addr), 32'h0077);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'd0, 16'd300, 1'b1, 1'b0, 16'h0077, 8'h00, 8'hAB);
    @(negedge clk);
    chk("rst no ack",      32'(bus.O_cpu_ack),     32'd0);
    chk("rst mem_addr",    32'(bus.O_mem_addr),    32'd0);
    chk("rst mem_wdata",   32'(bus.O_mem_wdata),   32'd0);
    chk("rst pixel",       32'(bus.O_pixel),       32'd0);
    chk("rst cpu_rdata",   32'(bus.O_cpu_rdata),   32'd0);
    chk("rst stall_count", 32'(bus.O_stall_count), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'd0, 16'd300, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hCD);
    @(negedge clk);
    chk("post-rst no ack",    32'(bus.O_cpu_ack),   32'd0);
    chk("post-rst mem_addr",  32'(bus.O_mem_addr),  32'd0);
    chk("post-rst cpu_rdata", 32'(bus.O_cpu_rdata), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'd0, 16'd300, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    @(posedge clk); #1;
    // Strobe two cycles after the last slot 0: must restart slot 0.
    drive(1'b1, 1'b1, 16'd3, 16'd2, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    @(negedge clk);
    chk("resync video addr", 32'(bus.O_mem_addr), 32'h0203);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'd3, 16'd2, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h4D);
    @(negedge clk);
    chk("resync pixel_valid", 32'(bus.O_pixel_valid), 32'd1);
    chk("resync pixel",       32'(bus.O_pixel),       32'h4D);
    @(posedge clk); #1;

    // CPU write colliding with a video read; ack awaited with a cycle budget.
    drive(1'b1, 1'b1, 16'd20, 16'd0, 1'b1, 1'b1, 16'h0500, 8'h99, 8'h00);
    @(negedge clk);
    chk("coll-wr video addr", 32'(bus.O_mem_addr), 32'h0014);
    chk("coll-wr video we",   32'(bus.O_mem_we),   32'd0);
    @(posedge clk); #1;
    ack_at = -1;
    for (int i = 1; i <= 6 && ack_at < 0; i++) begin
      drive(1'b1, 1'b0, 16'd20, 16'd0, 1'b1, 1'b1, 16'h0500, 8'h99, 8'h00);
      @(negedge clk);
      if (i == 1) begin
        chk("coll-wr grant we",    32'(bus.O_mem_we),    32'd1);
        chk("coll-wr grant addr",  32'(bus.O_mem_addr),  32'h0500);
        chk("coll-wr grant wdata", 32'(bus.O_mem_wdata), 32'h99);
      end
      if (bus.O_cpu_ack) ack_at = i;
      @(posedge clk); #1;
    end
    chk("coll-wr ack cycle", 32'(ack_at), 32'd2);
    drive(1'b1, 1'b0, 16'd0, 16'd300, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
- Shares one single-port synchronous pixel memory between two requesters: the scanout fetch, which follows the video timing counters, and a CPU-side request/acknowledge port.
- Each pixel period (4 I_clock cycles, marked by the pixel-clock rise strobe) reserves one slot for the scanout read. The CPU gets every other memory cycle.
- Sits between the video timing generator, the frame memory and the CPU bus bridge.

Parameters:
P_addr_width, 16, memory address width
P_data_width, 8, memory/pixel data width
P_active_h, 256, active pixels per line
P_active_v, 240, active lines per frame
P_base, 0, frame base address in memory

Ports:
I_clock  in  1  system clock
I_reset  in  1  reset: one clock; reset is synchronous and active-low
I_clk_rise  in  1  pixel-clock rise strobe, one cycle per pixel period
I_hcount  in  16  horizontal counter from timing generator
I_vcount  in  16  vertical counter from timing generator
O_mem_addr  out  P_addr_width  memory address
O_mem_we  out  1  memory write enable
O_mem_wdata  out  P_data_width  memory write data
I_mem_rdata  in  P_data_width  memory read data, valid 1 cycle after address
O_pixel  out  P_data_width  fetched scanout pixel
O_pixel_valid  out  1  one-cycle strobe, O_pixel updated
I_cpu_req  in  1  CPU request, held until O_cpu_ack
I_cpu_we  in  1  CPU write (1) / read (0), stable with req
I_cpu_addr  in  P_addr_width  CPU address, stable with req
I_cpu_wdata  in  P_data_width  CPU write data, stable with req
O_cpu_ack  out  1  one-cycle completion strobe
O_cpu_rdata  out  P_data_width  CPU read data, valid with ack (read), held after
O_stall_count  out  16  CPU stall statistics (optional feature)

Behaviour:
- Reset (I_reset low at a clock edge):
  - All outputs 0.
  - Slot counter 0; issue/return pipeline empty.
  - Any outstanding CPU read is dropped and produces no ack.
- Slot counter (2-bit):
  - Forced to 0 in the cycle I_clk_rise=1; otherwise increments mod 4.
  - Resynchronises on every strobe, even if the spacing is not 4.
- Fetch window:
  - Active when I_vcount < P_active_v and I_hcount < P_active_h.
  - Sampled combinationally in the slot-0 cycle.
- Issue stage, one memory access per cycle, priority video > CPU:
  - Video read:
    - Issued in the slot-0 cycle when the window is active.
    - O_mem_addr = P_base + I_vcount*P_active_h + I_hcount, truncated to P_addr_width; O_mem_we=0.
  - CPU grant:
    - Conditions: I_cpu_req=1, no reserved video read this cycle, no CPU access in the return stage, O_cpu_ack not asserted this cycle.
    - Result: O_mem_addr=I_cpu_addr, O_mem_we=I_cpu_we, O_mem_wdata=I_cpu_wdata.
  - Outside the window, slot 0 is available to the CPU.
  - When idle: O_mem_we=0; O_mem_addr holds its last value.
- Return stage (tag: none/video/cpu_rd/cpu_wr, registered at issue):
  - video: O_pixel <= I_mem_rdata and O_pixel_valid=1 for one cycle, i.e. the cycle after the slot-0 issue.
  - cpu_rd: O_cpu_rdata <= I_mem_rdata, O_cpu_ack=1.
  - cpu_wr: O_cpu_ack=1; the write took effect at the issue edge.
  - CPU latency is grant+1. The minimum CPU turnaround is 2 cycles (no grant in the ack cycle), so one request is never granted twice.
- Worst-case CPU wait when slot 0 is reserved: the request is granted in slot 1.
- Boundary conditions:
  - Video read and CPU return in the same cycle are legal (pipelined); both outputs update.
  - Address arithmetic wraps modulo 2^P_addr_width.
  - I_cpu_req dropped before ack: the behaviour is undefined and need not be protected. A read already granted still acks.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: O_stall_count increments each cycle with I_cpu_req=1 and no grant and no ack.
  - Saturates at 16'hFFFF.
  - Clears to 0 on reset and in the cycle I_clk_rise=1 with I_hcount=0 and I_vcount=0.
- Undefined: counter not built; O_stall_count tied to 0.

Test Plan:
- Scanout fetch: vcount=1, hcount=5, strobe.
  - Slot-0 address 16'h0105, we=0.
  - With rdata=8'hA5, next cycle O_pixel=8'hA5 and O_pixel_valid=1 for exactly 1 cycle.
- CPU write during blanking: vcount=245, req we=1 addr=16'h1234 wdata=8'h3C at slot 0.
  - Granted same cycle (mem_we=1, addr 16'h1234); ack next cycle.
  - No video read in that frame line.
- Collision: CPU read req asserted in the slot-0 cycle with window active (hcount=10, vcount=0).
  - Video address 16'h000A issued; CPU granted in slot 1; ack in slot 2 with rdata from memory.
- Back-to-back CPU: req held continuously outside the window.
  - Grants every 2nd cycle; 4 accesses complete in 8 cycles; never 2 acks in consecutive cycles.
- Reset mid-read: CPU read granted, I_reset low next edge.
  - No ack; all outputs 0.
  - After release, the first strobe restarts slot 0.
- VRAM_ARB_STATS_EN: hold req through 3 consecutive reserved slot-0 collisions.
  - O_stall_count=3.
  - Clears to 0 on the frame-start strobe (hcount=0, vcount=0).
